// File: rtl/dadda_mult4.sv
/*------------------------------------------------------------------------
 * dadda_mult4 : registered 4x4 unsigned multiplier (Dadda tree + ripple CPA)
 * Rev 1.0
 *----------------------------------------------------------------------*/
`default_nettype none

module dadda_mult4_ha (
   input  logic x_i,
   input  logic y_i,
   output logic s_o,
   output logic c_o
);
   assign s_o = x_i ^ y_i;
   assign c_o = x_i & y_i;
endmodule

module dadda_mult4_fa (
   input  logic x_i,
   input  logic y_i,
   input  logic z_i,
   output logic s_o,
   output logic c_o
);
   assign s_o = x_i ^ y_i ^ z_i;
   assign c_o = (x_i & y_i) | (z_i & (x_i ^ y_i));
endmodule

module dadda_mult4 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   input  logic [3:0] a,
   input  logic [3:0] b,
   output logic [7:0] op,
   output logic       out_valid
);
   logic [3:0] a_q, b_q;
   logic       v_q;
   logic [7:0] op_q, op_d;
   logic       out_valid_q;
   logic [3:0] pp [4];
   logic [7:0] w_sum;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_pp
         assign pp[gi] = {4{a_q[gi]}} & b_q;   // pp[i][j], weight i+j
      end
   endgenerate

   // Stage 1: heights 1,2,3,4,3,2,1 -> max 3
   logic s1_3, c1_4, s2_4, c2_5;
   dadda_mult4_ha u_ha1 (.x_i(pp[3][0]), .y_i(pp[2][1]), .s_o(s1_3), .c_o(c1_4));
   dadda_mult4_ha u_ha2 (.x_i(pp[3][1]), .y_i(pp[2][2]), .s_o(s2_4), .c_o(c2_5));

   // Stage 2: heights -> max 2
   logic s3_2, c3_3, s4_3, c4_4, s5_4, c5_5, s6_5, c6_6;
   dadda_mult4_ha u_ha3 (.x_i(pp[2][0]), .y_i(pp[1][1]), .s_o(s3_2), .c_o(c3_3));
   dadda_mult4_fa u_fa4 (.x_i(s1_3), .y_i(pp[1][2]), .z_i(pp[0][3]), .s_o(s4_3), .c_o(c4_4));
   dadda_mult4_fa u_fa5 (.x_i(s2_4), .y_i(pp[1][3]), .z_i(c1_4),     .s_o(s5_4), .c_o(c5_5));
   dadda_mult4_fa u_fa6 (.x_i(pp[3][2]), .y_i(pp[2][3]), .z_i(c2_5), .s_o(s6_5), .c_o(c6_6));

   // Final ripple-carry adder over the two remaining rows
   logic [6:1] k;
   assign w_sum[0] = pp[0][0];
   dadda_mult4_ha u_cpa1 (.x_i(pp[1][0]), .y_i(pp[0][1]), .s_o(w_sum[1]), .c_o(k[1]));
   dadda_mult4_fa u_cpa2 (.x_i(s3_2), .y_i(pp[0][2]), .z_i(k[1]), .s_o(w_sum[2]), .c_o(k[2]));
   dadda_mult4_fa u_cpa3 (.x_i(s4_3), .y_i(c3_3),     .z_i(k[2]), .s_o(w_sum[3]), .c_o(k[3]));
   dadda_mult4_fa u_cpa4 (.x_i(s5_4), .y_i(c4_4),     .z_i(k[3]), .s_o(w_sum[4]), .c_o(k[4]));
   dadda_mult4_fa u_cpa5 (.x_i(s6_5), .y_i(c5_5),     .z_i(k[4]), .s_o(w_sum[5]), .c_o(k[5]));
   dadda_mult4_fa u_cpa6 (.x_i(pp[3][3]), .y_i(c6_6), .z_i(k[5]), .s_o(w_sum[6]), .c_o(k[6]));
   assign w_sum[7] = k[6];

   always_comb begin
      op_d = op_q;
      if (v_q) op_d = w_sum;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q         <= 4'h0;
         b_q         <= 4'h0;
         v_q         <= 1'b0;
         op_q        <= 8'h00;
         out_valid_q <= 1'b0;
      end else begin
         if (in_valid) begin
            a_q <= a;
            b_q <= b;
         end
         v_q         <= in_valid;
         op_q        <= op_d;
         out_valid_q <= v_q;
      end
   end

   assign op        = op_q;
   assign out_valid = out_valid_q;
endmodule

`default_nettype wire

// File: tb/tb_dadda_mult4.sv
/*------------------------------------------------------------------------
 * tb_dadda_mult4 : directed + random self-checking bench for dadda_mult4
 * Rev 1.0
 *----------------------------------------------------------------------*/
`default_nettype none

module tb_dadda_mult4;
   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       in_valid = 1'b0;
   logic [3:0] a = 4'h0, b = 4'h0;
   logic [7:0] op;
   logic       out_valid;

   int checks = 0;
   int failures = 0;

   // Reference: product appears on the edge after the capturing edge
   logic       pend_v = 1'b0;
   logic [7:0] pend_p = 8'h00;
   logic       exp_v = 1'b0;
   logic [7:0] exp_op = 8'h00;

   dadda_mult4 dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
      .a(a), .b(b), .op(op), .out_valid(out_valid)
   );

   always #5 clk = ~clk;

   task automatic chk_op(input string tag, input logic [7:0] exp);
      checks++;
      assert (op === exp) else begin
         failures++;
         $error("FAIL %s op observed=%0d expected=%0d", tag, op, exp);
      end
   endtask

   task automatic chk_v(input string tag, input logic exp);
      checks++;
      assert (out_valid === exp) else begin
         failures++;
         $error("FAIL %s out_valid observed=%0b expected=%0b", tag, out_valid, exp);
      end
   endtask

   task automatic model_reset();
      pend_v = 1'b0; pend_p = 8'h00; exp_v = 1'b0; exp_op = 8'h00;
   endtask

   task automatic step(input string tag, input logic v, input logic [3:0] aa, input logic [3:0] bb);
      in_valid = v; a = aa; b = bb;
      @(posedge clk);
      exp_v = pend_v;
      if (pend_v) exp_op = pend_p;
      pend_v = v;
      pend_p = 8'(aa) * 8'(bb);
      #1;
      chk_op(tag, exp_op);
      chk_v(tag, exp_v);
   endtask

   task automatic async_reset();
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      chk_op("async_rst", 8'h00);
      chk_v("async_rst", 1'b0);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      int ok;
      logic [3:0] ca [5];
      logic [3:0] cb [5];
      ca = '{4'd0, 4'd15, 4'd15, 4'd1, 4'd8};
      cb = '{4'd0, 4'd15, 4'd1, 4'd15, 4'd8};

      // reset asserted mid-cycle with no clock edge
      @(posedge clk);
      async_reset();
      for (int i = 0; i < 5; i++) step("idle", 1'b0, 4'h0, 4'h0);

      // basic 6*6
      step("basic_cap", 1'b1, 4'd6, 4'd6);
      step("basic_out", 1'b0, 4'd0, 4'd0);
      chk_op("basic_36", 8'd36);
      step("basic_hold", 1'b0, 4'd0, 4'd0);
      chk_op("basic_hold36", 8'd36);

      // corners back-to-back
      for (int i = 0; i < 5; i++) step("corner", 1'b1, ca[i], cb[i]);
      step("corner_tail", 1'b0, 4'd0, 4'd0);
      chk_op("corner_last64", 8'd64);
      step("corner_idle", 1'b0, 4'd0, 4'd0);

      // exhaustive stream
      for (int i = 0; i < 256; i++) step("exh", 1'b1, 4'(i >> 4), 4'(i));
      step("exh_tail", 1'b0, 4'd0, 4'd0);
      chk_op("exh_last225", 8'd225);
      step("exh_idle", 1'b0, 4'd0, 4'd0);

      // reset in flight
      step("rif_cap", 1'b1, 4'd9, 4'd7);
      async_reset();
      step("rif_after", 1'b0, 4'd0, 4'd0);
      chk_v("rif_no_valid", 1'b0);
      step("rif_after2", 1'b0, 4'd0, 4'd0);
      step("rif_new", 1'b1, 4'd3, 4'd5);
      step("rif_out", 1'b0, 4'd0, 4'd0);
      chk_op("rif_15", 8'd15);

      // hold with changing operands
      step("hold_cap", 1'b1, 4'd12, 4'd11);
      step("hold_out", 1'b0, 4'd3, 4'd4);
      chk_op("hold_132", 8'd132);
      for (int i = 0; i < 4; i++) step("hold", 1'b0, 4'($urandom), 4'($urandom));
      chk_op("hold_132b", 8'd132);

      // random stream with random bubbles
      for (int i = 0; i < 400; i++) begin
         ok = int'($urandom_range(0, 3));
         step("rand", ok != 0, 4'($urandom), 4'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

`default_nettype wire

// File: doc/dadda_mult4.md
Name: dadda_mult4

Overview:
4x4 unsigned multiplier built as a Dadda reduction tree of partial products followed by a final carry-propagate adder, wrapped in input and output registers. It is the arithmetic leaf used wherever a small registered 4-bit product is needed. It has no control logic beyond a valid pipeline.

Parameters:
None. Operand width is fixed at 4 bits and product width at 8 bits.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  qualifies a and b for capture on this clock edge
a  input  4  multiplicand, unsigned
b  input  4  multiplier, unsigned
op  output  8  product a*b, unsigned, registered
out_valid  output  1  high for one cycle when op holds a new product

Behaviour:
- Reset: rst_n low asynchronously clears the input registers (a_r, b_r, v_r), op to 8'h00, and out_valid to 0, with no clock required. Release is synchronous in effect: the first capture occurs on the first rising clk edge with rst_n high.
- Stage 1, input register: on each rising edge with in_valid=1, capture a_r<=a, b_r<=b, v_r<=1. With in_valid=0, a_r and b_r hold their values and v_r<=0.
- Partial products: pp[i][j] = a_r[i] & b_r[j], 16 bits. Bit weight is i+j. Maximum column height is 4, at weight 3.
- Dadda reduction uses the height sequence 4 -> 3 -> 2.
  - Each stage uses only as many half/full adders as needed to bring every column to the target height.
  - Reduction is performed lowest column first, and carries feed the next column of the same stage.
  - Gate-level half/full adder cells are required; behavioural '*' is not allowed.
- Final adder: the two remaining rows feed a ripple-carry adder of half/full adder cells, producing 8 bits. The carry out of bit 7 is always 0 and is dropped.
- Stage 2, output register: on each rising edge, op<=tree_result when v_r=1, otherwise op holds its value. out_valid<=v_r every cycle.
- Latency: 2 clock edges from the capturing in_valid edge to out_valid=1 and op valid.
- Throughput: one product per cycle with back-to-back in_valid and no bubbles.
- Range: full 0..225. No overflow is possible; op == a*b exactly for all 256 operand pairs.
- Reset mid-operation: in-flight products are discarded and out_valid stays 0 until new in_valid captures propagate through.
- With in_valid held 0, op keeps the last product indefinitely.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with no clk edge -> op=8'h00 and out_valid=0 immediately. Release, with in_valid=0 for 5 cycles -> op stays 8'h00 and out_valid stays 0.
- Basic: a=4'b0110, b=4'b0110, in_valid=1 for one cycle -> two edges later op=8'd36 (8'h24) and out_valid=1 for exactly one cycle, then op holds 36.
- Corners, back-to-back: send 0*0, 15*15, 15*1, 1*15, 8*8 -> op sequence 0, 225 (8'hE1), 15, 15, 64, with out_valid high 5 consecutive cycles.
- Exhaustive: all 256 (a,b) pairs streamed continuously -> every out_valid cycle has op == a*b in input order. No mismatches allowed.
- Reset in flight: issue 9*7 and, one cycle later, pulse rst_n low -> no out_valid for 9*7, and op=0 after reset. A subsequent 3*5 yields op=15 two edges after capture.
- Hold: a=12, b=11 with in_valid=1, then change a and b with in_valid=0 -> op stays 132 (8'h84) and out_valid=0 after the single valid pulse.
